// File: rtl/vga_fb_arbiter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_arbiter_if
// Groups the pixel-writer handshake and the frame-buffer RAM bus of the
// frame-buffer arbiter.
//   wr_valid/wr_ready/wr_addr/wr_data : writer -> arbiter, transfer on valid&ready
//   mem_en/mem_we/mem_addr/mem_wdata  : arbiter -> single-port RAM
//   mem_rdata                         : RAM -> arbiter, valid 1 cycle after a read
// Modports:
//   master : the arbiter (owns the RAM bus, answers the writer)
//   slave  : the environment (writer plus RAM)
// -----------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port frame-buffer RAM between VGA scanout and a pixel
// writer. Scanout reads always win; a full-frame clear engine and a small
// write FIFO use the non-display cycles.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   disp_ena, row, col timing generator: visible pixel and its position
//   bus (master)       writer handshake + RAM bus (see vga_fb_arbiter_if)
//   clr_req, clr_color start a frame clear with the given colour (pulse)
//   clr_busy           clear in progress
//   clr_done           pulse on the cycle the last clear write is issued
//   wr_drop            pulse when a popped FIFO entry is out of range
//   pix_data,pix_valid scanout pixel, one cycle after the read slot
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int H_BITS    = 8,
    parameter int V_BITS    = 7,
    parameter int H_PIXELS  = 150,
    parameter int V_PIXELS  = 75,
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 14,
    parameter int FIFO_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_ena,
    input  logic [V_BITS-1:0] row,
    input  logic [H_BITS-1:0] col,
    vga_fb_arbiter_if.master  bus,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    localparam int                 DEPTH     = 2 ** FIFO_LOG2;
    localparam int                 TOTAL     = H_PIXELS * V_PIXELS;
    // One bit wider so the range check works even when TOTAL == 2**ADDR_W.
    localparam logic [ADDR_W:0]    TOTAL_W   = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [FIFO_LOG2:0] DEPTH_W   = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;
    logic [DATA_W-1:0]   clr_color_reg, clr_color_next;

    // Write FIFO: each entry is {address, data}.
    logic [ADDR_W+DATA_W-1:0] fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_LOG2:0]       count_reg;
    logic                     fifo_full, fifo_empty;
    logic                     push, pop;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     head_in_range;

    logic [ADDR_W-1:0]   pix_addr;
    logic                pix_valid_reg;

    logic                mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                clr_done_c, wr_drop_c;

    // Linear scanout address: row * stride + col.
    assign pix_addr = ADDR_W'(row) * ADDR_W'(H_PIXELS) + ADDR_W'(col);

    assign fifo_full  = (count_reg == DEPTH_W);
    assign fifo_empty = (count_reg == '0);
    // No bypass: a full FIFO refuses the push even if it pops this cycle.
    assign push       = bus.wr_valid && !fifo_full;

    assign {head_addr, head_data} = fifo_mem[rd_ptr_reg];
    assign head_in_range          = ({1'b0, head_addr} < TOTAL_W);

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {bus.wr_addr, bus.wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            clr_ptr_reg   <= '0;
            clr_color_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pix_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_ptr_reg   <= clr_ptr_next;
            clr_color_reg <= clr_color_next;
            pix_valid_reg <= disp_ena;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Slot arbitration and clear FSM.
    always_comb begin
        state_next     = state_reg;
        clr_ptr_next   = clr_ptr_reg;
        clr_color_next = clr_color_reg;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        pop            = 1'b0;
        clr_done_c     = 1'b0;
        wr_drop_c      = 1'b0;

        if (disp_ena) begin
            mem_en   = 1'b1;
            mem_addr = pix_addr;
        end else if (state_reg == CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_ptr_reg;
            mem_wdata = clr_color_reg;
        end else if (!fifo_empty) begin
            pop = 1'b1;
            if (head_in_range) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end else begin
                wr_drop_c = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next     = CLEAR;
                    clr_ptr_next   = '0;
                    clr_color_next = clr_color;
                end
            end
            CLEAR: begin
                // The pointer only moves when the clear actually got the slot;
                // clr_req is deliberately ignored here.
                if (!disp_ena) begin
                    if (clr_ptr_reg == LAST_ADDR) begin
                        clr_done_c = 1'b1;
                        state_next = IDLE;
                    end else begin
                        clr_ptr_next = clr_ptr_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Keep the combinational outputs quiet while reset is asserted,
        // even if the timing generator is still running.
        if (!rst_n) begin
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            clr_done_c = 1'b0;
            wr_drop_c  = 1'b0;
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.wr_ready  = !fifo_full;

    assign clr_busy  = (state_reg == CLEAR);
    assign clr_done  = clr_done_c;
    assign wr_drop   = wr_drop_c;
    assign pix_valid = pix_valid_reg;
    // The RAM read port is registered, so mem_rdata already arrives one cycle
    // after the read slot; it only needs qualifying here.
    assign pix_data  = pix_valid_reg ? bus.mem_rdata : '0;
endmodule
